// File: rtl/mmio_io_pkg.sv
// mmio_io_pkg: I/O window address map, TCTRL bit positions and the hex-to-seven-segment table.
package mmio_io_pkg;
  localparam logic [13:0] IO_BASE  = 14'h3C00;
  localparam logic [13:0] A_LED    = 14'h3C00;
  localparam logic [13:0] A_DIGIT  = 14'h3C01;
  localparam logic [13:0] A_SWITCH = 14'h3C02;
  localparam logic [13:0] A_TCOUNT = 14'h3C03;
  localparam logic [13:0] A_TCMP   = 14'h3C04;
  localparam logic [13:0] A_TCTRL  = 14'h3C05;
  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_FLAG = 1;
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
endpackage

// File: rtl/mmio_io_hub_seg7_scan.sv
// seg7_scan: time-multiplexes the nibbles of value across DIGITS active-low common displays.
module seg7_scan
  import mmio_io_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 20000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     seg_en,
  output logic [7:0]            seg
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
  // blank the display outright while reset is held
  assign seg_en = rst ? '1 : ~(DIGITS'(1) << idx);
  assign seg    = rst ? 8'hFF : SEG_LUT[value[4*idx +: 4]];
endmodule

// File: rtl/mmio_io_hub.sv
// mmio_io_hub: CPU data-bus I/O decoder with LED/digit registers, debounced switches and a match timer.
module mmio_io_hub
  import mmio_io_pkg::*;
#(
  parameter int SW_W     = 24,
  parameter int LED_W    = 24,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 20000,
  parameter int DEB_CYC  = 1000,
  parameter int ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led,
  output logic [DIGITS-1:0] seg_en,
  output logic [7:0]        seg
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(IO_BASE);
  localparam int DW = $clog2(DEB_CYC + 1);
  logic [4*DIGITS-1:0] digit;
  logic [SW_W-1:0]     s1, s2, last, sw;
  logic [DW-1:0]       deb_cnt, deb_n;
  logic [31:0]         tcount, tcmp, io;
  logic                en, flag, io_blk, t_hit;
  logic                wr_led, wr_digit, wr_tcount, wr_tcmp, wr_tctrl;
  // the whole 8-word block is claimed so the two holes never reach RAM
  assign io_blk    = adr[ADDR_W-1:3] == BASE[ADDR_W-1:3];
  assign mem_we    = we & ~io_blk;
  assign wr_led    = we && adr == ADDR_W'(A_LED);
  assign wr_digit  = we && adr == ADDR_W'(A_DIGIT);
  assign wr_tcount = we && adr == ADDR_W'(A_TCOUNT);
  assign wr_tcmp   = we && adr == ADDR_W'(A_TCMP);
  assign wr_tctrl  = we && adr == ADDR_W'(A_TCTRL);
  assign t_hit     = en && tcount == tcmp;
  assign deb_n     = (s2 != last) ? DW'(1) : deb_cnt + DW'(1);
  always_comb begin
    io = adr == ADDR_W'(A_LED)    ? 32'(led)   :
         adr == ADDR_W'(A_DIGIT)  ? 32'(digit) :
         adr == ADDR_W'(A_SWITCH) ? 32'(sw)    :
         adr == ADDR_W'(A_TCOUNT) ? tcount     :
         adr == ADDR_W'(A_TCMP)   ? tcmp       :
         adr == ADDR_W'(A_TCTRL)  ? {30'd0, flag, en} : 32'd0;
    rdata = io_blk ? io : mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      led     <= '0;
      digit   <= '0;
      s1      <= '0;
      s2      <= '0;
      last    <= '0;
      sw      <= '0;
      deb_cnt <= '0;
      tcount  <= '0;
      tcmp    <= '1;
      en      <= 1'b0;
      flag    <= 1'b0;
    end else begin
      if (wr_led) led <= wdata[LED_W-1:0];
      if (wr_digit) digit <= wdata[4*DIGITS-1:0];
      s1   <= switch;
      s2   <= s1;
      last <= s2;
      // deb_n counts consecutive cycles the synchronised value has held
      if (s2 == sw) deb_cnt <= '0;
      else if (deb_n >= DW'(DEB_CYC)) begin
        sw      <= s2;
        deb_cnt <= '0;
      end else deb_cnt <= deb_n;
      if (wr_tcount) tcount <= wdata;
      else if (en) tcount <= t_hit ? 32'd0 : tcount + 32'd1;
      if (wr_tcmp) tcmp <= wdata;
      if (wr_tctrl) en <= wdata[TCTRL_EN];
      flag <= (t_hit && !wr_tcount) || (flag && !(wr_tctrl && wdata[TCTRL_FLAG]));
    end
  end
  seg7_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) u_scan (
    .clk   (clk),
    .rst   (rst),
    .value (digit),
    .seg_en(seg_en),
    .seg   (seg)
  );
endmodule

// File: tb/tb_mmio_io_hub.sv
// tb_mmio_io_hub: directed scenarios for the I/O hub with small debounce and scan constants.
module tb_mmio_io_hub;
  import mmio_io_pkg::*;
  logic        clk = 0, rst = 1, we = 0;
  logic [13:0] adr = '0;
  logic [31:0] wdata = '0, rdata, mem_rdata = '0;
  logic        mem_we;
  logic [23:0] switch = '0, led;
  logic [3:0]  seg_en;
  logic [7:0]  seg;
  int checks = 0, failures = 0;

  mmio_io_hub #(.SW_W(24), .LED_W(24), .DIGITS(4), .SCAN_DIV(2), .DEB_CYC(4), .ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .we(we), .adr(adr), .wdata(wdata), .rdata(rdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .switch(switch), .led(led),
    .seg_en(seg_en), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [13:0] a);
    adr = a;
    we  = 0;
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    adr = a;
    wdata = d;
    we = 1;
    step();
    we = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) step();
    checks++; if (seg_en !== 4'hF) begin failures++; $display("FAIL rst_seg_en got=%h exp=f", seg_en); end
    checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL rst_seg got=%h exp=ff", seg); end
    rst = 0;
    rd(A_LED);
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL rst_led got=%h exp=0", rdata); end
    rd(A_TCMP);
    checks++; if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_tcmp got=%h exp=ffffffff", rdata); end
    rd(A_TCTRL);
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL rst_tctrl got=%h exp=0", rdata); end
  endtask

  task automatic test_led();
    adr = A_LED; wdata = 32'h00A5_A5A5; we = 1;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL led_mem_we got=%b exp=0", mem_we); end
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL led_prewrite got=%h exp=0", rdata); end
    step();
    we = 0;
    checks++; if (led !== 24'hA5A5A5) begin failures++; $display("FAIL led_out got=%h exp=a5a5a5", led); end
    checks++; if (rdata !== 32'h00A5_A5A5) begin failures++; $display("FAIL led_read got=%h exp=00a5a5a5", rdata); end
    wr(A_LED, 32'hFFFF_FF00);
    rd(A_LED);
    checks++; if (rdata !== 32'h00FF_FF00) begin failures++; $display("FAIL led_trunc got=%h exp=00ffff00", rdata); end
  endtask

  task automatic test_mem();
    adr = 14'h0010; wdata = 32'h1111_2222; we = 1; mem_rdata = 32'h1234_5678;
    #1;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL mem_we got=%b exp=1", mem_we); end
    step();
    we = 0;
    rd(14'h0010);
    checks++; if (rdata !== 32'h1234_5678) begin failures++; $display("FAIL mem_read got=%h exp=12345678", rdata); end
    checks++; if (led !== 24'hFFFF00) begin failures++; $display("FAIL mem_led_kept got=%h exp=ffff00", led); end
    adr = 14'h3BFF; we = 1;
    #1;
    checks++; if (mem_we !== 1'b1 || rdata !== 32'h1234_5678) begin failures++; $display("FAIL below_window got=%b/%h exp=1/12345678", mem_we, rdata); end
    adr = 14'h3C06;
    #1;
    checks++; if (mem_we !== 1'b0 || rdata !== 32'd0) begin failures++; $display("FAIL hole got=%b/%h exp=0/0", mem_we, rdata); end
    adr = 14'h3C08;
    #1;
    checks++; if (mem_we !== 1'b1 || rdata !== 32'h1234_5678) begin failures++; $display("FAIL above_window got=%b/%h exp=1/12345678", mem_we, rdata); end
    we = 0;
    rd(A_DIGIT);
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL mem_digit_kept got=%h exp=0", rdata); end
  endtask

  task automatic test_debounce();
    wr(A_SWITCH, 32'h00FF_FFFF);
    rd(A_SWITCH);
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL sw_write_ignored got=%h exp=0", rdata); end
    switch = 24'h5;
    repeat (3) step();
    switch = 24'h0;
    repeat (6) step();
    rd(A_SWITCH);
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL sw_bounce got=%h exp=0", rdata); end
    switch = 24'h5;
    repeat (5) step();
    rd(A_SWITCH);
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL sw_early got=%h exp=0", rdata); end
    step();
    rd(A_SWITCH);
    checks++; if (rdata !== 32'h5) begin failures++; $display("FAIL sw_accept got=%h exp=5", rdata); end
  endtask

  task automatic test_timer();
    logic [31:0] seq [4] = '{32'd1, 32'd2, 32'd3, 32'd0};
    wr(A_TCMP, 32'd3);
    wr(A_TCTRL, 32'd1);
    rd(A_TCOUNT);
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL tc_start got=%h exp=0", rdata); end
    for (int i = 0; i < 4; i++) begin
      step();
      rd(A_TCOUNT);
      checks++; if (rdata !== seq[i]) begin failures++; $display("FAIL tc_seq%0d got=%h exp=%h", i, rdata, seq[i]); end
    end
    rd(A_TCTRL);
    checks++; if (rdata !== 32'd3) begin failures++; $display("FAIL tc_flag_set got=%h exp=3", rdata); end
    wr(A_TCTRL, 32'd3);
    rd(A_TCTRL);
    checks++; if (rdata !== 32'd1) begin failures++; $display("FAIL tc_flag_clr got=%h exp=1", rdata); end
    rd(A_TCOUNT);
    checks++; if (rdata !== 32'd1) begin failures++; $display("FAIL tc_after_clr got=%h exp=1", rdata); end
    repeat (2) step();
    wr(A_TCTRL, 32'd3);
    rd(A_TCTRL);
    checks++; if (rdata !== 32'd3) begin failures++; $display("FAIL tc_set_wins got=%h exp=3", rdata); end
    rd(A_TCOUNT);
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL tc_set_wins_cnt got=%h exp=0", rdata); end
    wr(A_TCTRL, 32'd3);
    wr(A_TCOUNT, 32'd3);
    rd(A_TCOUNT);
    checks++; if (rdata !== 32'd3) begin failures++; $display("FAIL tc_write got=%h exp=3", rdata); end
    wr(A_TCOUNT, 32'd7);
    rd(A_TCOUNT);
    checks++; if (rdata !== 32'd7) begin failures++; $display("FAIL tc_write_beats got=%h exp=7", rdata); end
    rd(A_TCTRL);
    checks++; if (rdata !== 32'd1) begin failures++; $display("FAIL tc_write_noflag got=%h exp=1", rdata); end
    wr(A_TCTRL, 32'd0);
    step();
    rd(A_TCOUNT);
    checks++; if (rdata !== 32'd8) begin failures++; $display("FAIL tc_disabled got=%h exp=8", rdata); end
  endtask

  task automatic test_reset_mid();
    wr(A_TCTRL, 32'd1);
    wr(A_LED, 32'h0012_3456);
    wr(A_DIGIT, 32'h0000_BEEF);
    switch = 24'h5A;
    repeat (8) step();
    rd(A_SWITCH);
    checks++; if (rdata !== 32'h5A) begin failures++; $display("FAIL mid_sw_pre got=%h exp=5a", rdata); end
    rst = 1;
    #1;
    checks++; if (seg_en !== 4'hF || seg !== 8'hFF) begin failures++; $display("FAIL mid_blank got=%h/%h exp=f/ff", seg_en, seg); end
    step();
    checks++; if (led !== 24'd0) begin failures++; $display("FAIL mid_led got=%h exp=0", led); end
    rd(A_SWITCH);
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL mid_sw got=%h exp=0", rdata); end
    rd(A_TCOUNT);
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL mid_tcount got=%h exp=0", rdata); end
    rd(A_TCMP);
    checks++; if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mid_tcmp got=%h exp=ffffffff", rdata); end
    rd(A_DIGIT);
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL mid_digit got=%h exp=0", rdata); end
    switch = 24'h0;
    rst = 0;
  endtask

  task automatic test_scan();
    logic [3:0] en_exp  [7] = '{4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110};
    logic [7:0] seg_exp [7] = '{8'hB0, 8'hB0, 8'hA4, 8'hA4, 8'hF9, 8'hF9, 8'h99};
    rst = 1;
    step();
    rst = 0;
    wr(A_DIGIT, 32'h0000_1234);
    checks++; if (seg_en !== 4'b1110 || seg !== 8'h99) begin failures++; $display("FAIL scan_d0 got=%b/%h exp=1110/99", seg_en, seg); end
    for (int i = 0; i < 7; i++) begin
      step();
      checks++; if (seg_en !== en_exp[i] || seg !== seg_exp[i]) begin failures++; $display("FAIL scan_step%0d got=%b/%h exp=%b/%h", i, seg_en, seg, en_exp[i], seg_exp[i]); end
    end
    wr(A_DIGIT, 32'h0000_123A);
    checks++; if (seg_en !== 4'b1110 || seg !== 8'h88) begin failures++; $display("FAIL scan_update got=%b/%h exp=1110/88", seg_en, seg); end
    step();
    checks++; if (seg_en !== 4'b1101 || seg !== 8'hB0) begin failures++; $display("FAIL scan_phase got=%b/%h exp=1101/b0", seg_en, seg); end
  endtask

  initial begin
    test_reset();
    test_led();
    test_mem();
    test_debounce();
    test_timer();
    test_reset_mid();
    test_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
